life_step_ctrl: RTL and testbench

LIFE_STEP_CTRL -- requirements
Module: life_step_ctrl

---
 rtl/life_step_ctrl_pkg.sv | 13 +
 rtl/life_step_ctrl_btn_debounce.sv | 42 ++++
 rtl/life_step_ctrl.sv | 108 ++++++++++
 tb/tb_life_step_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/life_step_ctrl_pkg.sv
// Shared definitions for the life step controller: FSM encoding and parameter defaults.
package life_step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    REQ     = 2'd2
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 250000;
  localparam int GEN_W_DEF           = 16;

endpackage

// File: rtl/life_step_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability debounce and a one-cycle press pulse.
module btn_debounce
  import life_step_ctrl_pkg::*;
#(
  parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          r_press;
  logic          w_diff;
  logic          w_done;

  // r_cnt counts consecutive samples that disagree with the debounced level
  assign w_diff = r_sync[1] ^ r_db;
  assign w_done = w_diff && (r_cnt == CW'(CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_cnt   <= (w_diff && !w_done) ? r_cnt + CW'(1) : '0;
      if (w_done) r_db <= ~r_db;
      r_press <= w_done & ~r_db;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/life_step_ctrl.sv
// Generation step controller: paces life-engine requests by frame ticks (free-run) or button presses.
// Define LIFE_GEN_COUNT_EN to build the completed-generation counter; otherwise gen_count is tied to 0.
module life_step_ctrl
  import life_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SPEED_W         = 4,
  parameter int GEN_W           = GEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_mode,
  input  logic               step_btn,
  input  logic               vsync,
  input  logic [SPEED_W-1:0] speed,
  input  logic               step_ack,
  output logic               step_req,
  output logic               busy,
  output logic [GEN_W-1:0]   gen_count
);

  logic [1:0]         r_rm_sync;
  logic [2:0]         r_vs_sync;
  logic [SPEED_W-1:0] r_frame;
  logic               r_pend;
  logic               r_req;
  state_t             r_state;
  state_t             w_state_n;
  logic               w_run;
  logic               w_tick;
  logic               w_press;
  logic               w_expire;
  logic               w_set;
  logic               w_clr;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (step_btn),
    .o_press (w_press)
  );

  // third vsync flop only serves the falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rm_sync <= '0;
      r_vs_sync <= '1;
    end else begin
      r_rm_sync <= {r_rm_sync[0], run_mode};
      r_vs_sync <= {r_vs_sync[1:0], vsync};
    end
  end

  assign w_run    = r_rm_sync[1];
  assign w_tick   = r_vs_sync[2] & ~r_vs_sync[1];
  assign w_expire = w_run & w_tick & (r_frame == speed);
  assign w_set    = w_expire | (~w_run & w_press);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_frame <= '0;
    else if (!w_run)  r_frame <= '0;
    else if (w_tick)  r_frame <= w_expire ? '0 : r_frame + SPEED_W'(1);
  end

  always_comb begin
    w_state_n = r_state;
    w_clr     = 1'b0;
    unique case (r_state)
      IDLE:    if (r_pend) w_state_n = WAIT_VS;
      WAIT_VS: if (w_tick) begin
        w_state_n = REQ;
        w_clr     = 1'b1;
      end
      REQ:     if (step_ack) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // a new request source wins over the clear, so an expiry on the launching tick is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_req   <= (w_state_n == REQ);
    end
  end

  assign step_req = r_req;
  assign busy     = r_req;

`ifdef LIFE_GEN_COUNT_EN
  logic [GEN_W-1:0] r_gen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_gen <= '0;
    else if (r_state == REQ && step_ack) r_gen <= r_gen + GEN_W'(1);
  end

  assign gen_count = r_gen;
`else
  assign gen_count = '0;
`endif

endmodule

// File: tb/tb_life_step_ctrl.sv
// Bench for life_step_ctrl: cycle model of the stepping rules plus directed scenarios and random traffic.
module tb_life_step_ctrl;
  localparam int DB    = 8;
  localparam int FRAME = 40;
  localparam int VSW   = 3;
  localparam int GW    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_mode = 1'b0;
  logic       step_btn = 1'b0;
  logic       vsync = 1'b1;
  logic [3:0] speed = 4'd2;
  logic       ack_resp = 1'b0;
  logic       ack_man = 1'b0;
  logic       step_ack;
  logic       step_req, busy;
  logic [GW-1:0] gen_count;

  assign step_ack = ack_resp | ack_man;

  life_step_ctrl #(.DEBOUNCE_CYCLES(DB), .SPEED_W(4), .GEN_W(GW)) dut (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn), .vsync(vsync),
    .speed(speed), .step_ack(step_ack), .step_req(step_req), .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, vs_fall_cyc = 0, n_rise = 0, last_rise_cyc = 0;
  int ack_dly = 5;
  bit ack_en = 1'b1, cmp_en = 1'b0, prev_req = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit m_r1, m_r2, m_b1, m_b2, m_v1 = 1, m_v2 = 1, m_v3 = 1;
  bit m_db, m_press, m_pend, m_req;
  int m_run, m_frame, m_phase, m_gen;   // m_phase: 0 idle, 1 waiting for frame, 2 requesting

  always @(posedge clk or posedge rst) begin
    bit tick, set, clr, npress;
    if (rst) begin
      m_r1 = 0; m_r2 = 0; m_b1 = 0; m_b2 = 0; m_v1 = 1; m_v2 = 1; m_v3 = 1;
      m_db = 0; m_press = 0; m_pend = 0; m_req = 0;
      m_run = 0; m_frame = 0; m_phase = 0; m_gen = 0;
    end else begin
      tick = m_v3 && !m_v2;
      set = 0; clr = 0; npress = 0;
      if (m_b2 != m_db) begin
        m_run++;
        if (m_run == DB) begin m_db = !m_db; npress = m_db; m_run = 0; end
      end else m_run = 0;
      if (!m_r2) begin
        m_frame = 0;
        if (m_press) set = 1;
      end else if (tick) begin
        if (m_frame == int'(speed)) begin m_frame = 0; set = 1; end
        else m_frame = (m_frame + 1) % 16;
      end
      case (m_phase)
        0: if (m_pend) m_phase = 1;
        1: if (tick) begin m_phase = 2; clr = 1; end
        default: if (step_ack) begin m_phase = 0; m_gen = (m_gen + 1) % (1 << GW); end
      endcase
      m_pend = (m_pend && !clr) || set;
      m_press = npress;
      m_req = (m_phase == 2);
      m_v3 = m_v2; m_v2 = m_v1; m_v1 = vsync;
      m_b2 = m_b1; m_b1 = step_btn;
      m_r2 = m_r1; m_r1 = run_mode;
    end
  end

  function automatic int exp_gen(input int g);
`ifdef LIFE_GEN_COUNT_EN
    return g;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) if (cmp_en) begin
    chk(step_req === m_req, "step_req", step_req, m_req);
    chk(busy === m_req, "busy", busy, m_req);
    chk(gen_count === GW'(exp_gen(m_gen)), "gen_count", gen_count, exp_gen(m_gen));
  end

  always @(negedge clk) begin
    if (step_req === 1'b1 && !prev_req) begin n_rise++; last_rise_cyc = cyc; end
    prev_req = (step_req === 1'b1);
  end

  // ---------------- environment ----------------
  initial forever begin
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == FRAME - VSW) begin vsync = 1'b0; vs_fall_cyc = cyc; end
      else if (i == 0) vsync = 1'b1;
    end
  end

  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (ack_resp) ack_resp = 1'b0;
      else if (ack_en && step_req === 1'b1) begin
        cnt++;
        if (cnt >= ack_dly) begin ack_resp = 1'b1; cnt = 0; end
      end else cnt = 0;
    end
  end

  task automatic wait_rise(input int lim, input string nm);
    int s = n_rise;
    int k = 0;
    while (n_rise == s && k < lim) begin @(negedge clk); #1; k++; end
    chk(n_rise != s, nm, n_rise - s, 1);
  endtask

  task automatic wait_fall(input int lim, input string nm);
    int k = 0;
    while (step_req === 1'b1 && k < lim) begin @(negedge clk); #1; k++; end
    chk(step_req === 1'b0, nm, step_req, 0);
  endtask

  task automatic wait_vs_fall();
    int s = vs_fall_cyc;
    for (int k = 0; k < 2 * FRAME && vs_fall_cyc == s; k++) begin @(negedge clk); #1; end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int base, prev_rise;
    bit any_req;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (4) @(negedge clk);
    chk(step_req === 1'b0, "reset_req", step_req, 0);
    chk(busy === 1'b0, "reset_busy", busy, 0);
    chk(gen_count === '0, "reset_gen", gen_count, 0);
    rst = 1'b0;

    // free-run, speed 2: one request every 3 frames, 3 cycles after the raw vsync fall
    run_mode = 1'b1; speed = 4'd2; ack_dly = 5;
    prev_rise = 0;
    for (int n = 1; n <= 5; n++) begin
      wait_rise(5 * FRAME, "fr_rise");
      chk(last_rise_cyc - vs_fall_cyc == 3, "fr_tick_lat", last_rise_cyc - vs_fall_cyc, 3);
      if (n > 1) chk(last_rise_cyc - prev_rise == 3 * FRAME, "fr_period", last_rise_cyc - prev_rise, 3 * FRAME);
      prev_rise = last_rise_cyc;
      wait_fall(20, "fr_fall");
      if (n >= 3) chk(gen_count === GW'(exp_gen(n)), "fr_gen_wrap", gen_count, exp_gen(n) % 4);
    end

    // mode switch while busy: in-flight step completes, then nothing without a press
    wait_rise(4 * FRAME, "sw_rise");
    run_mode = 1'b0;
    wait_fall(20, "sw_complete");
    base = n_rise;
    repeat (5 * FRAME) @(negedge clk);
    chk(n_rise == base, "sw_no_req", n_rise - base, 0);

    // glitch shorter than the debounce window is ignored
    step_btn = 1'b1; repeat (3) @(negedge clk); step_btn = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    chk(n_rise == base, "glitch_no_req", n_rise - base, 0);
    step_btn = 1'b1; repeat (20) @(negedge clk); step_btn = 1'b0;
    wait_rise(3 * FRAME, "press_rise");
    chk(last_rise_cyc - vs_fall_cyc == 3, "press_tick_lat", last_rise_cyc - vs_fall_cyc, 3);
    wait_fall(20, "press_fall");
    repeat (3 * FRAME) @(negedge clk);
    chk(n_rise == base + 1, "press_once", n_rise - base, 1);

    // two presses inside one frame collapse to one step
    wait_vs_fall();
    base = n_rise;
    step_btn = 1'b1; repeat (12) @(negedge clk);
    step_btn = 1'b0; repeat (12) @(negedge clk);
    step_btn = 1'b1; repeat (12) @(negedge clk);
    step_btn = 1'b0;
    repeat (4 * FRAME) @(negedge clk);
    chk(n_rise == base + 1, "two_press_one_req", n_rise - base, 1);

    // asynchronous reset while requesting, then a late ack
    ack_en = 1'b0; run_mode = 1'b1; speed = 4'd0;
    wait_rise(4 * FRAME, "rst_rise");
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk(step_req === 1'b0, "rst_async_req", step_req, 0);
    chk(busy === 1'b0, "rst_async_busy", busy, 0);
    chk(gen_count === '0, "rst_async_gen", gen_count, 0);
    @(negedge clk); rst = 1'b0;
    ack_man = 1'b1; @(negedge clk); ack_man = 1'b0;
    any_req = 1'b0;
    repeat (10) begin @(negedge clk); #1; any_req |= (step_req === 1'b1); end
    chk(!any_req, "rst_late_ack_req", any_req, 0);
    chk(gen_count === '0, "rst_late_ack_gen", gen_count, 0);
    ack_en = 1'b1;

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(99) == 0) run_mode = ~run_mode;
      if ($urandom_range(49) == 0) speed = 4'($urandom_range(3));
      if ($urandom_range(9) == 0) step_btn = ~step_btn;
      ack_man = ($urandom_range(39) == 0);
      if (i % 200 == 0) ack_dly = $urandom_range(1, 8);
    end
    ack_man = 1'b0;
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
